// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap/return sequencer for the EX stage.
// Picks one event per valid IDLE cycle (illegal > ecall > mret > ext irq >
// timer irq), pulses the matching g_* line, flushes the pipe for FLUSH_CYC
// cycles, then issues a one-cycle PC redirect to mtvec (trap) or mepc (mret).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cpu_stat_ex, pc_ex          EX valid flag and EX PC [31:2]
//   illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex   EX decode flags
//   ext_irq_in, timer_irq_in    async external / sync timer request levels
//   csr_mstatus_mie, csr_meie, csr_mtie         interrupt enables
//   csr_mtvec_ex, csr_mepc_ex   trap vector / return address [31:2]
//   g_exception, g_interrupt, g_timer_int       one-cycle trap pulses
//   g_interrupt_priv, g_current_priv            fixed M-mode (2'b11)
//   pc_excep                    PC captured for mepc
//   pipe_flush                  kill IF/ID/EX and hold PC
//   redirect_valid, redirect_pc one-cycle PC load request and target
module trap_ctrl #(
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stat_ex,
    input  logic [31:2] pc_ex,
    input  logic        illegal_ops_ex,
    input  logic        cmd_ecall_ex,
    input  logic        cmd_mret_ex,
    input  logic        ext_irq_in,
    input  logic        timer_irq_in,
    input  logic        csr_mstatus_mie,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic [31:2] csr_mtvec_ex,
    input  logic [31:2] csr_mepc_ex,
    output logic        g_exception,
    output logic        g_interrupt,
    output logic        g_timer_int,
    output logic [1:0]  g_interrupt_priv,
    output logic [1:0]  g_current_priv,
    output logic [31:2] pc_excep,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:2] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH_TRAP,
        FLUSH_RET,
        REDIR
    } state_t;

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        sync1_q;
    logic        ext_irq_s;
    logic        ret_q;
    logic [31:2] pc_excep_q;
    logic        g_exception_q;
    logic        g_interrupt_q;
    logic        g_timer_q;
    logic        pipe_flush_q;
    logic        redirect_valid_q;

    logic ev_ok;
    logic take_exc;
    logic take_ret;
    logic take_ext;
    logic take_tmr;
    logic take_any;

    // Priority select; only evaluated while IDLE with a valid EX slot.
    always_comb begin
        take_exc = 1'b0;
        take_ret = 1'b0;
        take_ext = 1'b0;
        take_tmr = 1'b0;
        ev_ok    = cpu_stat_ex && (state_q == IDLE);
        if (ev_ok) begin
            if (illegal_ops_ex || cmd_ecall_ex) begin
                take_exc = 1'b1;
            end else if (cmd_mret_ex) begin
                take_ret = 1'b1;
            end else if (ext_irq_s && csr_meie && csr_mstatus_mie) begin
                take_ext = 1'b1;
            end else if (timer_irq_in && csr_mtie && csr_mstatus_mie) begin
                take_tmr = 1'b1;
            end
        end
        take_any = take_exc | take_ret | take_ext | take_tmr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            sync1_q          <= 1'b0;
            ext_irq_s        <= 1'b0;
            ret_q            <= 1'b0;
            pc_excep_q       <= '0;
            g_exception_q    <= 1'b0;
            g_interrupt_q    <= 1'b0;
            g_timer_q        <= 1'b0;
            pipe_flush_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            sync1_q          <= ext_irq_in;
            ext_irq_s        <= sync1_q;
            g_exception_q    <= 1'b0;
            g_interrupt_q    <= 1'b0;
            g_timer_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (take_any) begin
                        cnt_q         <= FLUSH_LD;
                        pipe_flush_q  <= 1'b1;
                        ret_q         <= take_ret;
                        g_exception_q <= take_exc;
                        g_interrupt_q <= take_ext;
                        g_timer_q     <= take_tmr;
                        if (take_ret) begin
                            state_q <= FLUSH_RET;
                        end else begin
                            state_q    <= FLUSH_TRAP;
                            pc_excep_q <= pc_ex;
                        end
                    end
                end
                FLUSH_TRAP, FLUSH_RET: begin
                    // Last flush cycle: drop flush, raise redirect next.
                    if (cnt_q == 4'd1) begin
                        state_q          <= REDIR;
                        cnt_q            <= 4'd0;
                        pipe_flush_q     <= 1'b0;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                REDIR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign g_exception      = g_exception_q;
    assign g_interrupt      = g_interrupt_q;
    assign g_timer_int      = g_timer_q;
    assign g_interrupt_priv = 2'b11;
    assign g_current_priv   = 2'b11;
    assign pc_excep         = pc_excep_q;
    assign pipe_flush       = pipe_flush_q;
    assign redirect_valid   = redirect_valid_q;

    // Target is sampled live in the REDIR cycle; zero otherwise.
    assign redirect_pc = !redirect_valid_q ? '0 :
                         ret_q ? csr_mepc_ex : csr_mtvec_ex;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 2: number of pipeline-flush cycles between trap/return acceptance and the PC redirect (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cpu_stat_ex, input, 1: EX stage holds a valid instruction this cycle.
REQ-005 SHALL have port pc_ex, input, 30 [31:2]: PC of the instruction in EX.
REQ-006 SHALL have ports illegal_ops_ex, cmd_ecall_ex and cmd_mret_ex, input, 1 each: EX-stage decode flags.
REQ-007 SHALL have ports ext_irq_in and timer_irq_in, input, 1 each: external interrupt (asynchronous level) and timer compare (synchronous level).
REQ-008 SHALL have ports csr_mstatus_mie, csr_meie and csr_mtie, input, 1 each: global, external and timer interrupt enables.
REQ-009 SHALL have ports csr_mtvec_ex and csr_mepc_ex, input, 30 [31:2]: trap vector and return address.
REQ-010 SHALL have ports g_exception, g_interrupt and g_timer_int, output, 1 each: one-cycle trap pulses toward the CSR block.
REQ-011 SHALL have ports g_interrupt_priv and g_current_priv, output, 2 each: target and current privilege, both fixed 2'b11 (M-mode).
REQ-012 SHALL have port pc_excep, output, 30 [31:2]: PC captured for mepc.
REQ-013 SHALL have port pipe_flush, output, 1: kill IF/ID/EX contents and hold PC.
REQ-014 SHALL have ports redirect_valid, output, 1, and redirect_pc, output, 30 [31:2]: one-cycle PC load request and its target.

Function
REQ-015 SHALL synchronize ext_irq_in through two flops; only the synchronized value (ext_irq_s) participates in decisions.
REQ-016 SHALL implement states IDLE, FLUSH_TRAP, FLUSH_RET and REDIR.
REQ-017 SHALL, in IDLE with cpu_stat_ex=1, select one event by priority illegal > ecall > mret > external irq > timer irq.
REQ-018 SHALL treat external irq as pending only when ext_irq_s & csr_meie & csr_mstatus_mie, and timer irq only when timer_irq_in & csr_mtie & csr_mstatus_mie.
REQ-019 SHALL ignore every event while cpu_stat_ex=0 or state!=IDLE; pending interrupt levels are re-evaluated on the next IDLE cycle.
REQ-020 SHALL, on accepting a trap in cycle T, drive exactly one of g_exception (illegal or ecall), g_interrupt or g_timer_int high during T+1 only, with pc_excep=pc_ex(T) registered and held until the next trap.
REQ-021 SHALL enter FLUSH_TRAP on a trap and FLUSH_RET on mret, assert pipe_flush from T+1 for exactly FLUSH_CYC cycles using a 4-bit down-counter, then enter REDIR.
REQ-022 SHALL, in REDIR, hold redirect_valid=1 for one cycle with redirect_pc=csr_mtvec_ex (after trap) or csr_mepc_ex (after mret), both sampled in that cycle, then return to IDLE.
REQ-023 SHALL keep pipe_flush=0 in the REDIR cycle and in IDLE.
REQ-024 SHALL, on simultaneous exception and pending interrupt, take the exception; the interrupt remains pending and is taken on the first valid IDLE cycle after the return to IDLE if still enabled.
REQ-025 SHALL give the trap-to-redirect latency as FLUSH_CYC+1 cycles after T; mret follows the same timing with no g_* pulse.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, force state=IDLE, counter=0, synchronizer flops=0, pc_excep=0, and all 1-bit outputs=0; redirect_pc SHALL read 0 in reset.
REQ-027 SHALL let reset during FLUSH_* or REDIR abort the sequence with no redirect_valid pulse afterward.

Verification
REQ-028 SHALL cover: illegal_ops_ex=1, pc_ex=0x100, mtvec=0x200 at T -> g_exception=1 at T+1, pc_excep=0x100, pipe_flush T+1..T+2, redirect_valid at T+3 with redirect_pc=0x200.
REQ-029 SHALL cover: ext_irq_in asserted, meie=mie=1, cpu_stat_ex=1 -> g_interrupt pulse 3 cycles after the rising edge (2 sync + 1), redirect to mtvec.
REQ-030 SHALL cover: illegal_ops_ex and timer pending in the same cycle -> g_exception only; g_timer_int fires on the first valid IDLE cycle after redirect.
REQ-031 SHALL cover: cmd_mret_ex with mepc=0x180 -> no g_* pulse, flush for 2 cycles, redirect_pc=0x180.
REQ-032 SHALL cover: ext irq pending with csr_mstatus_mie=0 -> no trap; setting mie=1 -> trap taken on the next valid cycle.
REQ-033 SHALL cover: rst=1 in the second FLUSH cycle -> no redirect_valid; outputs 0 and state IDLE on the cycle after release.
